bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 104 ++++++++++
 tb/tb_bus_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master, two-slave bus arbiter: host (M0) parks on the bus, DMAC (M1) borrows it
// with a bounded tenure while the host is waiting. Read data returns one cycle later.
module bus_arbiter #(
  parameter int MAX_TENURE = 16
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        M0_req,
  input  logic        M0_wr,
  input  logic [7:0]  M0_address,
  input  logic [31:0] M0_dout,
  input  logic        M1_req,
  input  logic        M1_wr,
  input  logic [7:0]  M1_address,
  input  logic [31:0] M1_dout,
  input  logic [31:0] S0_dout,
  input  logic [31:0] S1_dout,
  output logic        M0_grant,
  output logic        M1_grant,
  output logic [31:0] M_din,
  output logic        S0_sel,
  output logic        S1_sel,
  output logic [7:0]  S_address,
  output logic        S_wr,
  output logic [31:0] S_din
);

  typedef enum logic {M0_GRANT, M1_GRANT} state_e;

  localparam bit         TENURE_EN   = (MAX_TENURE != 0);
  localparam logic [7:0] TENURE_LAST = 8'(MAX_TENURE - 1);

  state_e      state_q, state_d;
  logic [7:0]  tenure_q, tenure_d;
  logic [1:0]  sel_q, sel_d;
  logic        busReq;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= M0_GRANT;
      tenure_q <= 8'd0;
      sel_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      tenure_q <= tenure_d;
      sel_q    <= sel_d;
    end
  end

  // Next state; the tenure counter only advances while the host is kept waiting.
  always_comb begin
    state_d  = state_q;
    tenure_d = 8'd0;
    case (state_q)
      M0_GRANT: begin
        if (!M0_req && M1_req) state_d = M1_GRANT;
      end
      M1_GRANT: begin
        if (!M1_req) begin
          state_d = M0_GRANT;
        end else if (TENURE_EN && M0_req && (tenure_q == TENURE_LAST)) begin
          state_d = M0_GRANT;
        end
        if (state_d == M1_GRANT) begin
          if (M0_req && (tenure_q != 8'hFF)) tenure_d = tenure_q + 8'd1;
          else                               tenure_d = tenure_q;
        end
      end
      default: state_d = M0_GRANT;
    endcase
  end

  always_comb begin
    M0_grant = (state_q == M0_GRANT);
    M1_grant = (state_q == M1_GRANT);
  end

  always_comb begin
    if (state_q == M1_GRANT) begin
      busReq    = M1_req;
      S_address = M1_address;
      S_din     = M1_dout;
      S_wr      = M1_wr & M1_req;
    end else begin
      busReq    = M0_req;
      S_address = M0_address;
      S_din     = M0_dout;
      S_wr      = M0_wr & M0_req;
    end
    // Only the low 64 addresses map to slaves; everything above is silently dropped.
    S0_sel = busReq && (S_address[7:5] == 3'd0);
    S1_sel = busReq && (S_address[7:5] == 3'd1);
    sel_d  = {S0_sel, S1_sel};
  end

  always_comb begin
    case (sel_q)
      2'b10:   M_din = S0_dout;
      2'b01:   M_din = S1_dout;
      default: M_din = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: grants, decode, read latency, tenure limit and reset.
module tb_bus_arbiter;

  logic        Clk = 1'b0;
  logic        reset;
  logic        M0_req, M0_wr, M1_req, M1_wr;
  logic [7:0]  M0_address, M1_address;
  logic [31:0] M0_dout, M1_dout, S0_dout, S1_dout;
  logic        M0_grant, M1_grant, S0_sel, S1_sel, S_wr;
  logic [31:0] M_din, S_din;
  logic [7:0]  S_address;

  int checks = 0;
  int failures = 0;

  bus_arbiter #(.MAX_TENURE(16)) dut (
    .Clk(Clk), .reset(reset),
    .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
    .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
    .S0_dout(S0_dout), .S1_dout(S1_dout),
    .M0_grant(M0_grant), .M1_grant(M1_grant), .M_din(M_din),
    .S0_sel(S0_sel), .S1_sel(S1_sel), .S_address(S_address), .S_wr(S_wr), .S_din(S_din)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic m0r, input logic m0w, input logic [7:0] m0a, input logic [31:0] m0d,
                               input logic m1r, input logic m1w, input logic [7:0] m1a, input logic [31:0] m1d);
    M0_req = m0r; M0_wr = m0w; M0_address = m0a; M0_dout = m0d;
    M1_req = m1r; M1_wr = m1w; M1_address = m1a; M1_dout = m1d;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    S0_dout = 32'd4;
    S1_dout = 32'h55;
    applyStimulus(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_m0_grant", 32'(M0_grant), 32'd1);
    checkOutput("rst_m1_grant", 32'(M1_grant), 32'd0);
    checkOutput("rst_s0_sel", 32'(S0_sel), 32'd0);
    checkOutput("rst_s1_sel", 32'(S1_sel), 32'd0);
    checkOutput("rst_m_din", M_din, 32'h0);

    // Host write to slave 0 is visible on the bus in the same cycle.
    applyStimulus(1, 1, 8'h03, 32'h0000000A, 0, 0, 8'h00, 32'h0);
    checkOutput("m0w_s0_sel", 32'(S0_sel), 32'd1);
    checkOutput("m0w_s1_sel", 32'(S1_sel), 32'd0);
    checkOutput("m0w_s_wr", 32'(S_wr), 32'd1);
    checkOutput("m0w_s_din", S_din, 32'h0000000A);
    checkOutput("m0w_s_addr", 32'(S_address), 32'h03);

    // Host read from slave 0, then slave 1; data arrives one cycle later.
    tick();
    applyStimulus(1, 0, 8'h07, 32'h0, 0, 0, 8'h00, 32'h0);
    checkOutput("m0r_s_wr", 32'(S_wr), 32'd0);
    tick();
    checkOutput("m0r_m_din_s0", M_din, 32'd4);
    applyStimulus(1, 0, 8'h25, 32'h0, 0, 0, 8'h00, 32'h0);
    checkOutput("m0r_s1_sel", 32'(S1_sel), 32'd1);
    tick();
    checkOutput("m0r_m_din_s1", M_din, 32'h55);

    // Handover to DMAC; grant moves only after the deciding edge.
    applyStimulus(0, 1, 8'h03, 32'h0, 1, 1, 8'h20, 32'd100);
    checkOutput("pre_m0_grant", 32'(M0_grant), 32'd1);
    checkOutput("pre_s_wr", 32'(S_wr), 32'd0);
    tick();
    checkOutput("m1_grant", 32'(M1_grant), 32'd1);
    checkOutput("m1_m0_grant", 32'(M0_grant), 32'd0);
    checkOutput("m1w_s1_sel", 32'(S1_sel), 32'd1);
    checkOutput("m1w_s0_sel", 32'(S0_sel), 32'd0);
    checkOutput("m1w_s_din", S_din, 32'd100);
    checkOutput("m1w_s_wr", 32'(S_wr), 32'd1);
    applyStimulus(0, 0, 8'h00, 32'h0, 0, 1, 8'h20, 32'd100);
    checkOutput("m1rel_s1_sel", 32'(S1_sel), 32'd0);
    tick();
    checkOutput("m1rel_m0_grant", 32'(M0_grant), 32'd1);

    // Tenure limit: host waits exactly 16 edges, then DMAC returns only once host drops.
    applyStimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0);
    tick();
    checkOutput("ten_m1_grant", 32'(M1_grant), 32'd1);
    applyStimulus(1, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checkOutput($sformatf("ten_hold_%0d", i), 32'(M1_grant), 32'd1);
    end
    tick();
    checkOutput("ten_expire_m0", 32'(M0_grant), 32'd1);
    checkOutput("ten_expire_m1", 32'(M1_grant), 32'd0);
    tick();
    tick();
    checkOutput("ten_both_req_m0", 32'(M0_grant), 32'd1);
    applyStimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0);
    tick();
    checkOutput("ten_regain_m1", 32'(M1_grant), 32'd1);

    // Out-of-range access by DMAC after a slave-1 read.
    tick();
    checkOutput("m1r_m_din_s1", M_din, 32'h55);
    applyStimulus(0, 0, 8'h00, 32'h0, 1, 1, 8'h80, 32'hDEAD);
    checkOutput("oor_s0_sel", 32'(S0_sel), 32'd0);
    checkOutput("oor_s1_sel", 32'(S1_sel), 32'd0);
    tick();
    checkOutput("oor_m_din", M_din, 32'h0);

    // Reset during DMAC ownership returns bus to host in one edge.
    applyStimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0);
    tick();
    checkOutput("prerst_m1_grant", 32'(M1_grant), 32'd1);
    checkOutput("prerst_m_din_s0", M_din, 32'd4);
    reset = 1'b1;
    tick();
    checkOutput("midrst_m0_grant", 32'(M0_grant), 32'd1);
    checkOutput("midrst_m1_grant", 32'(M1_grant), 32'd0);
    checkOutput("midrst_m_din", M_din, 32'h0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
